mac_tile_engine: RTL

MAC_TILE_ENGINE -- requirements
Module: mac_tile_engine

---
 rtl/mac_tile_engine_if.sv | 24 ++
 rtl/mac_tile_engine.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mac_tile_engine_if.sv
// Input and output AXI-stream handshakes of the MAC tile engine.
// The engine uses the slave modport; the stream source/sink uses the master modport.
interface mac_tile_engine_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tlast;
    logic                  s_axis_tready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tlast;
    logic                  m_axis_tready;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/mac_tile_engine.sv
// Fixed-point dense-layer tile: LANES parallel MACs over an INPUT_DIM-beat frame,
// then a serialised bias/shift/ReLU/saturate output of one word per lane.
module mac_tile_engine #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int LANES      = 8,
    parameter int INPUT_DIM  = 64,
    parameter int FRAC_BITS  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_relu_en,
    input  logic                         cfg_clr_err,
    input  logic                         w_wr_en,
    input  logic [$clog2(LANES)-1:0]     w_wr_lane,
    input  logic [$clog2(INPUT_DIM)-1:0] w_wr_addr,
    input  logic [DATA_WIDTH-1:0]        w_wr_data,
    input  logic                         b_wr_en,
    input  logic [$clog2(LANES)-1:0]     b_wr_lane,
    input  logic [DATA_WIDTH-1:0]        b_wr_data,
    mac_tile_engine_if.slave             axis,
    output logic                         busy,
    output logic                         frame_err
);
    localparam int LW = $clog2(LANES);
    localparam int AW = $clog2(INPUT_DIM);

    localparam logic [1:0] ST_ACCUM  = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_OUTPUT = 2'd2;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic [1:0]                   r_state;
    logic [AW-1:0]                r_k;
    logic [LW-1:0]                r_idx;
    logic                         r_live;
    logic                         r_err;
    logic                         r_relu;
    logic                         r_p_valid;
    logic                         r_p_first;
    logic signed [DATA_WIDTH-1:0] r_p_data;

    logic                         w_busy;
    logic                         w_accept;
    logic                         w_last_beat;
    logic                         w_out_fire;
    logic signed [ACC_WIDTH-1:0]  w_acc [LANES];
    logic signed [ACC_WIDTH-1:0]  w_sel;
    logic signed [ACC_WIDTH-1:0]  w_shift;
    logic [DATA_WIDTH-1:0]        w_word;

    // r_live holds tready low through reset and releases it on the first clock after.
    assign axis.s_axis_tready = r_live && (r_state == ST_ACCUM) && !w_wr_en && !b_wr_en;
    assign w_accept    = axis.s_axis_tvalid && axis.s_axis_tready;
    assign w_last_beat = (r_k == AW'(INPUT_DIM - 1));
    assign w_busy      = (r_state != ST_ACCUM) || (r_k != '0);
    assign w_out_fire  = axis.m_axis_tvalid && axis.m_axis_tready;
    assign busy        = w_busy;
    assign frame_err   = r_err;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [DATA_WIDTH-1:0]   r_wmem [INPUT_DIM];
        logic signed [DATA_WIDTH-1:0]   r_rd;
        logic signed [DATA_WIDTH-1:0]   r_bias;
        logic signed [ACC_WIDTH-1:0]    r_acc;
        logic signed [2*DATA_WIDTH-1:0] w_prod;
        logic signed [ACC_WIDTH-1:0]    w_base;

        // Weight RAM: no reset, registered read addressed by the current beat count.
        always_ff @(posedge clk) begin
            if (w_wr_en && !w_busy && (w_wr_lane == LW'(l))) begin
                r_wmem[w_wr_addr] <= w_wr_data;
            end
            r_rd <= r_wmem[r_k];
        end

        assign w_prod = r_p_data * r_rd;
        assign w_base = r_p_first
            ? ({{(ACC_WIDTH-DATA_WIDTH){r_bias[DATA_WIDTH-1]}}, r_bias} <<< FRAC_BITS)
            : r_acc;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_bias <= '0;
                r_acc  <= '0;
            end else begin
                if (b_wr_en && !w_busy && (b_wr_lane == LW'(l))) begin
                    r_bias <= b_wr_data;
                end
                if (r_p_valid) begin
                    r_acc <= w_base + {{(ACC_WIDTH-2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
                end
            end
        end

        assign w_acc[l] = r_acc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_ACCUM;
            r_k       <= '0;
            r_idx     <= '0;
            r_live    <= 1'b0;
            r_err     <= 1'b0;
            r_relu    <= 1'b0;
            r_p_valid <= 1'b0;
            r_p_first <= 1'b0;
            r_p_data  <= '0;
        end else begin
            r_live    <= 1'b1;
            r_p_valid <= w_accept;
            r_p_first <= w_accept && (r_k == '0);
            if (w_accept) begin
                r_p_data <= axis.s_axis_tdata;
            end
            if (w_accept && (w_last_beat != axis.s_axis_tlast)) begin
                r_err <= 1'b1;
            end else if (cfg_clr_err) begin
                r_err <= 1'b0;
            end
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        if (w_last_beat) begin
                            r_k     <= '0;
                            r_state <= ST_DRAIN;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_OUTPUT;
                    r_idx   <= '0;
                    r_relu  <= cfg_relu_en;
                end
                ST_OUTPUT: begin
                    if (w_out_fire) begin
                        if (r_idx == LW'(LANES - 1)) begin
                            r_state <= ST_ACCUM;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_ACCUM;
            endcase
        end
    end

    assign w_sel   = w_acc[r_idx];
    assign w_shift = w_sel >>> FRAC_BITS;

    always_comb begin
        w_word = w_shift[DATA_WIDTH-1:0];
        if (r_relu && w_shift[ACC_WIDTH-1]) begin
            w_word = '0;
        end else if (w_shift > SAT_MAX) begin
            w_word = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (w_shift < SAT_MIN) begin
            w_word = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
    end

    // Output word and lane index only change on a handshake, so they hold under backpressure.
    assign axis.m_axis_tvalid = (r_state == ST_OUTPUT);
    assign axis.m_axis_tdata  = axis.m_axis_tvalid ? w_word : '0;
    assign axis.m_axis_tlast  = axis.m_axis_tvalid && (r_idx == LW'(LANES - 1));
endmodule
